// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and sequencer for the single-port line memory
module mem_arbiter #(
  parameter int BITSIZE          = 32,
  parameter int N_WORDS_PER_ADDR = 4,
  parameter int TIMEOUT          = 16,
  localparam int LINE_W          = N_WORDS_PER_ADDR * BITSIZE
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic [1:0]        req_i,
  input  logic [31:0]       addr0_i,
  input  logic [31:0]       addr1_i,
  input  logic [LINE_W-1:0] wdata0_i,
  input  logic [LINE_W-1:0] wdata1_i,
  input  logic [1:0]        store_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  output logic              err_o,
  output logic [LINE_W-1:0] rdata_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_store_o,
  output logic              mem_valid_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_valid_i
);

  // Counter is wide enough to hold TIMEOUT-1; a one-bit counter covers TIMEOUT=1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          last_grant;
  logic          id;
  logic [CW-1:0] cnt;
  logic          win;
  logic          any_req;

  // Round-robin winner: on a tie the port that was not served last goes first.
  always_comb begin
    any_req = |req_i;
    win     = 1'b0;
    if (req_i == 2'b11) begin
      win = ~last_grant;
    end else begin
      win = req_i[1];
    end
    gnt_o = 2'b00;
    if (state == IDLE && !reset_i && any_req) begin
      gnt_o = win ? 2'b10 : 2'b01;
    end
  end

  // Sequencer: latch the winning command, hold the memory handshake, report completion.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      id          <= 1'b0;
      cnt         <= '0;
      done_o      <= 2'b00;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_store_o <= 1'b0;
      mem_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 2'b00;
          err_o  <= 1'b0;
          if (any_req) begin
            mem_addr_o  <= win ? addr1_i : addr0_i;
            mem_data_o  <= win ? wdata1_i : wdata0_i;
            mem_store_o <= store_i[win];
            id          <= win;
            last_grant  <= win;
            cnt         <= '0;
            mem_valid_o <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_valid_i) begin
            if (!mem_store_o) begin
              rdata_o <= mem_data_i;
            end
            mem_valid_o <= 1'b0;
            done_o      <= id ? 2'b10 : 2'b01;
            err_o       <= 1'b0;
            state       <= RESP;
          end else if (cnt == CNT_LAST) begin
            mem_valid_o <= 1'b0;
            done_o      <= id ? 2'b10 : 2'b01;
            err_o       <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          done_o <= 2'b00;
          err_o  <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  localparam int LINE_W = 128;

  logic              clk;
  logic              reset_i;
  logic [1:0]        req_i;
  logic [31:0]       addr0_i, addr1_i;
  logic [LINE_W-1:0] wdata0_i, wdata1_i;
  logic [1:0]        store_i;
  logic [1:0]        gnt_o, done_o;
  logic              err_o;
  logic [LINE_W-1:0] rdata_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_store_o, mem_valid_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_valid_i;

  typedef struct {
    logic [1:0]        done;
    logic              err;
    logic [LINE_W-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_arbiter #(.BITSIZE(32), .N_WORDS_PER_ADDR(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset_i(reset_i), .req_i(req_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .store_i(store_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_store_o(mem_store_o), .mem_valid_o(mem_valid_o),
    .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] line(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(k);
    return {w, w, w, w};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] d, input logic e, input logic [LINE_W-1:0] r);
    exp_t x;
    x.done  = d;
    x.err   = e;
    x.rdata = r;
    sb.push_back(x);
  endtask

  // Completion monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset_i && gnt_o != 2'b00) begin
      chk("gnt_onehot", {127'd0, gnt_o == 2'b11}, '0);
    end
    if (!reset_i && done_o != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {126'd0, done_o}, '0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("sb_done", {126'd0, done_o}, {126'd0, x.done});
        chk("sb_err", {127'd0, err_o}, {127'd0, x.err});
        chk("sb_rdata", rdata_o, x.rdata);
      end
    end
  end

  initial begin
    logic [1:0] exp_g;
    reset_i = 1'b1; req_i = 2'b00; store_i = 2'b00;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    mem_data_i = '0; mem_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", {126'd0, gnt_o}, '0);
    chk("rst_done", {126'd0, done_o}, '0);
    chk("rst_err", {127'd0, err_o}, '0);
    chk("rst_rdata", rdata_o, '0);
    chk("rst_valid", {127'd0, mem_valid_o}, '0);
    chk("rst_addr", {96'd0, mem_addr_o}, '0);
    reset_i = 1'b0;

    // single zero-wait load on port 0
    req_i = 2'b01; addr0_i = 32'h4; #1;
    chk("ld_gnt", {126'd0, gnt_o}, 128'h1);
    push(2'b01, 1'b0, {4{32'hAAAA_AAAA}});
    next();
    req_i = 2'b00; mem_valid_i = 1'b1; mem_data_i = {4{32'hAAAA_AAAA}}; #1;
    chk("ld_valid", {127'd0, mem_valid_o}, 128'h1);
    chk("ld_store", {127'd0, mem_store_o}, '0);
    chk("ld_addr", {96'd0, mem_addr_o}, 128'h4);
    next();
    mem_valid_i = 1'b0; mem_data_i = '0; #1;
    chk("ld_done", {126'd0, done_o}, 128'h1);
    chk("ld_rdata", rdata_o, {4{32'hAAAA_AAAA}});
    chk("ld_valid_low", {127'd0, mem_valid_o}, '0);
    next();

    // store on port 1; command must be held only until grant
    req_i = 2'b10; store_i = 2'b10; addr1_i = 32'h10; wdata1_i = 128'h1234; #1;
    chk("st_gnt", {126'd0, gnt_o}, 128'h2);
    push(2'b10, 1'b0, {4{32'hAAAA_AAAA}});
    next();
    req_i = 2'b00; store_i = 2'b00; addr1_i = 32'hDEAD; wdata1_i = '1;
    mem_valid_i = 1'b1; mem_data_i = {4{32'h5555_5555}}; #1;
    chk("st_valid", {127'd0, mem_valid_o}, 128'h1);
    chk("st_store", {127'd0, mem_store_o}, 128'h1);
    chk("st_addr", {96'd0, mem_addr_o}, 128'h10);
    chk("st_data", mem_data_o, 128'h1234);
    next();
    mem_valid_i = 1'b0; #1;
    chk("st_done", {126'd0, done_o}, 128'h2);
    chk("st_rdata_kept", rdata_o, {4{32'hAAAA_AAAA}});
    next();

    // contention: both ports held high, strict alternation starting with port 0
    req_i = 2'b11; addr0_i = 32'h100; addr1_i = 32'h200;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("rr_gnt", {126'd0, gnt_o}, {126'd0, exp_g});
      push(exp_g, 1'b0, line(i));
      next();
      mem_valid_i = 1'b1; mem_data_i = line(i); #1;
      chk("rr_addr", {96'd0, mem_addr_o}, (exp_g == 2'b01) ? 128'h100 : 128'h200);
      next();
      mem_valid_i = 1'b0; #1;
      chk("rr_resp_no_gnt", {126'd0, gnt_o}, '0);
      chk("rr_done", {126'd0, done_o}, {126'd0, exp_g});
      next();
    end
    req_i = 2'b00;

    // five wait states: mem_valid_o high for six cycles
    req_i = 2'b01; addr0_i = 32'h40; #1;
    chk("ws_gnt", {126'd0, gnt_o}, 128'h1);
    push(2'b01, 1'b0, line(10));
    next();
    req_i = 2'b00;
    for (int k = 0; k < 6; k++) begin
      mem_valid_i = (k == 5); mem_data_i = line(10); #1;
      chk("ws_valid", {127'd0, mem_valid_o}, 128'h1);
      chk("ws_no_done", {126'd0, done_o}, '0);
      next();
    end
    mem_valid_i = 1'b0; mem_data_i = '0; #1;
    chk("ws_done", {126'd0, done_o}, 128'h1);
    chk("ws_valid_low", {127'd0, mem_valid_o}, '0);
    next();

    // timeout: memory never answers
    req_i = 2'b01; addr0_i = 32'h44; #1;
    chk("to_gnt", {126'd0, gnt_o}, 128'h1);
    push(2'b01, 1'b1, line(10));
    next();
    req_i = 2'b00;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("to_valid", {127'd0, mem_valid_o}, 128'h1);
      chk("to_no_done", {126'd0, done_o}, '0);
      next();
    end
    #1;
    chk("to_done", {126'd0, done_o}, 128'h1);
    chk("to_err", {127'd0, err_o}, 128'h1);
    chk("to_valid_low", {127'd0, mem_valid_o}, '0);
    next();
    #1;
    chk("to_idle_done", {126'd0, done_o}, '0);
    chk("to_idle_err", {127'd0, err_o}, '0);

    // stray memory response in IDLE is ignored
    mem_valid_i = 1'b1; mem_data_i = line(77); next();
    mem_valid_i = 1'b0; #1;
    chk("stray_rdata", rdata_o, line(10));
    chk("stray_done", {126'd0, done_o}, '0);

    // reset during the second ACCESS cycle abandons the transaction
    req_i = 2'b01; addr0_i = 32'h80; #1;
    chk("rm_gnt", {126'd0, gnt_o}, 128'h1);
    next();
    req_i = 2'b00; #1;
    chk("rm_acc1", {127'd0, mem_valid_o}, 128'h1);
    next();
    reset_i = 1'b1; #1;
    chk("rm_acc2", {127'd0, mem_valid_o}, 128'h1);
    next();
    reset_i = 1'b0; #1;
    chk("rm_valid", {127'd0, mem_valid_o}, '0);
    chk("rm_done", {126'd0, done_o}, '0);
    chk("rm_err", {127'd0, err_o}, '0);
    chk("rm_rdata", rdata_o, '0);
    chk("rm_addr", {96'd0, mem_addr_o}, '0);
    chk("rm_data", mem_data_o, '0);
    chk("rm_store", {127'd0, mem_store_o}, '0);
    chk("rm_gnt_idle", {126'd0, gnt_o}, '0);
    req_i = 2'b11; #1;
    chk("rm_tie_gnt", {126'd0, gnt_o}, 128'h1);
    push(2'b01, 1'b0, line(20));
    next();
    req_i = 2'b00; mem_valid_i = 1'b1; mem_data_i = line(20); next();
    mem_valid_i = 1'b0; #1;
    chk("rm_final_done", {126'd0, done_o}, 128'h1);
    repeat (3) next();

    chk("sb_empty", 128'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port line memory: port 0 is instruction fetch, port 1 is data load/store.
- Selects one requester per transaction with round-robin priority, registers its command, and drives the memory valid/store handshake.
- Captures the returned line and signals completion to the winning port.
- Includes a response timeout so a missing memory handshake cannot hang the core.

Parameters:
- BITSIZE, 32, word width in bits.
- N_WORDS_PER_ADDR, 4, words per memory line; LINE_W = N_WORDS_PER_ADDR*BITSIZE (128 by default).
- TIMEOUT, 16, maximum cycles spent in ACCESS waiting for mem_valid_i; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_i  in  2  per-port request; bit 0 is fetch, bit 1 is data.
- addr0_i, addr1_i  in  32 each  per-port byte address, passed to memory unchanged.
- wdata0_i, wdata1_i  in  LINE_W each  per-port store line.
- store_i  in  2  per-port store flag; 1 = store, 0 = load.
- gnt_o  out  2  one-hot, one-cycle pulse when a port's request is accepted.
- done_o  out  2  one-hot, one-cycle pulse when the granted transaction completes.
- err_o  out  1  high together with done_o when the transaction timed out.
- rdata_o  out  LINE_W  last loaded line.
- mem_addr_o  out  32  memory address.
- mem_data_o  out  LINE_W  memory write data.
- mem_store_o  out  1  memory store flag.
- mem_valid_o  out  1  memory request valid.
- mem_data_i  in  LINE_W  memory read data.
- mem_valid_i  in  1  memory response valid; may be asserted combinationally in the same cycle as mem_valid_o.

Behaviour:
- Reset values (all outputs): gnt_o=0, done_o=0, err_o=0, rdata_o=0, mem_addr_o=0, mem_data_o=0, mem_store_o=0, mem_valid_o=0.
- Reset internal state: FSM=IDLE, last_grant=1, so port 0 wins the first tie.
- Reset asserted mid-transaction: the transaction is abandoned, no done_o is issued, and the FSM returns to IDLE on the next edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, arbitration (combinational on req_i):
  - one request pending: that port wins.
  - both pending: the port != last_grant wins (round-robin).
  - gnt_o[winner]=1 in this same cycle.
- IDLE, on the clock edge after a grant:
  - register addr, wdata, store and port id; set last_grant=winner; go to ACCESS.
  - requesters must hold addr/wdata/store stable until they see gnt_o, and may change them afterwards.
- IDLE with no request: stay in IDLE; all handshake outputs are 0.
- ACCESS:
  - mem_valid_o=1; mem_addr_o, mem_data_o and mem_store_o are driven from the registered command.
  - wait counter starts at 0 on entry and increments every ACCESS cycle.
  - if mem_valid_i=1: for a load, capture mem_data_i into rdata_o; for a store, rdata_o is unchanged. Go to RESP with err=0.
  - else if the counter reaches TIMEOUT-1: go to RESP with err=1; rdata_o is unchanged.
- RESP:
  - mem_valid_o=0; done_o[id]=1 for one cycle; err_o = the registered err value.
  - always go to IDLE next. The RESP cycle never grants, so new arbitration happens in the following IDLE cycle.
- Latency with a zero-wait memory: gnt in cycle 0, ACCESS in cycle 1, done in cycle 2. The next grant is possible in cycle 3, giving a peak throughput of one access per 3 cycles.
- rdata_o holds its value until the next completed load; it is valid from the done_o cycle onward.
- req_i deasserted after grant: the transaction still completes and done_o still pulses.
- req_i held high through done: treated as a new request in the next IDLE cycle.
- mem_valid_i while not in ACCESS: ignored.
- mem_addr_o, mem_data_o and mem_store_o keep their last values outside ACCESS; they are only qualified by mem_valid_o.
- Only one port is ever granted or done in a given cycle.

Test Plan:
- Reset then single load: req_i=01, addr0_i=0x4, memory returns 0xAAAA_..._AAAA with zero wait → gnt_o=01 at cycle 0, mem_valid_o=1 and mem_store_o=0 at cycle 1, done_o=01 and rdata_o=0xAAAA..AAAA at cycle 2, err_o=0.
- Store from data port: req_i=10, store_i=10, addr1_i=0x10, wdata1_i=0x1234 → mem_valid_o=1, mem_store_o=1, mem_addr_o=0x10, mem_data_o=0x1234 in ACCESS; done_o=10; rdata_o unchanged.
- Contention: req_i=11 held for 4 transactions → grant order 01,10,01,10; done_o order matches; gnt_o never 11.
- Wait states: memory asserts mem_valid_i 5 cycles after mem_valid_o rises → done_o 1 cycle after the response, err_o=0, mem_valid_o high for exactly 6 cycles.
- Timeout: TIMEOUT=16, mem_valid_i never asserted → mem_valid_o high for 16 cycles, then done_o=01 with err_o=1, rdata_o unchanged, FSM back in IDLE.
- Reset mid-ACCESS: assert reset_i during the 2nd ACCESS cycle → the next cycle shows mem_valid_o=0 and all outputs at reset values, no done_o, and the next tie grants port 0.
